// File: rtl/in_cell_capture_sched_pkg.sv
// Shared types and constants for the input-cell capture scheduler.
package in_cell_sched_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        SAMPLE,
        RESP
    } sched_state_e;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/in_cell_capture_sched_rr_arbiter_pri.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NREQ. The pointer itself lives in the parent.
module rr_arbiter_pri
    import in_cell_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]           req,
    input  logic [id_width(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]           gnt,
    output logic [id_width(NREQ)-1:0] idx,
    output logic                      any
);

    localparam int IDW = id_width(NREQ);

    logic [IDW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/in_cell_capture_sched.sv
// Round-robin scheduler sharing one registered input-cell bank between NREQ
// requesters: clear, settle, sample, then return the IQZ vector.
module in_cell_capture_sched
    import in_cell_sched_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic                      IQC,
    input  logic                      QRT_N,
    input  logic [NREQ-1:0]           REQ,
    output logic [NREQ-1:0]           GNT,
    output logic                      CELL_QRT,
    input  logic [WIDTH-1:0]          CELL_IQZ,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [id_width(NREQ)-1:0] RSP_ID,
    output logic [WIDTH-1:0]          RSP_DATA,
    output logic                      BUSY
);

    localparam int IDW = id_width(NREQ);
    localparam logic [CNT_W-1:0] CLR_INIT    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

    if (WIDTH < 1 || NREQ < 2 || NREQ > 8 || CLR_CYC < 1 || CLR_CYC > 15 ||
        SETTLE_CYC < 0 || SETTLE_CYC > 15) begin : g_bad_params
        $error("in_cell_capture_sched: parameter out of range");
    end

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_d;
    logic [IDW-1:0]   rsp_id_d;
    logic [WIDTH-1:0] rsp_data_d;
    logic             rsp_valid_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;

    rr_arbiter_pri #(.NREQ(NREQ)) u_arb (
        .req (REQ),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = GNT;
        rsp_id_d    = RSP_ID;
        rsp_data_d  = RSP_DATA;
        rsp_valid_d = RSP_VALID;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d  = CLEAR;
                    cnt_d    = CLR_INIT;
                    gnt_d    = arb_gnt;
                    rsp_id_d = arb_idx;
                    ptr_d    = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == '0) begin
                    if (SETTLE_CYC == 0) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                rsp_data_d  = CELL_IQZ;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    gnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The bank is held cleared throughout reset and whenever CLEAR is entered.
    always_ff @(posedge IQC or negedge QRT_N) begin
        if (!QRT_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            GNT       <= '0;
            CELL_QRT  <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_DATA  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            GNT       <= gnt_d;
            CELL_QRT  <= (state_d == CLEAR);
            RSP_VALID <= rsp_valid_d;
            RSP_ID    <= rsp_id_d;
            RSP_DATA  <= rsp_data_d;
        end
    end

    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_in_cell_capture_sched.sv
// Self-checking bench: default-parameter scheduler plus a CLR_CYC=1/SETTLE_CYC=0
// instance, both compared against a behavioural round-robin/latency model.
module tb_in_cell_capture_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic             IQC = 1'b0;
    logic             QRT_N;
    logic [NREQ-1:0]  req;
    logic             ready;
    logic [WIDTH-1:0] iqz;
    logic [WIDTH-1:0] iqz_at_edge;
    bit               sel;

    logic [NREQ-1:0]  req_m, req_e, gnt_m, gnt_e;
    logic             ready_m, ready_e;
    logic             qrt_m, qrt_e, valid_m, valid_e, busy_m, busy_e;
    logic [1:0]       id_m, id_e;
    logic [WIDTH-1:0] data_m, data_e;

    logic [NREQ-1:0]  cur_gnt;
    logic             cur_qrt, cur_valid, cur_busy;
    logic [1:0]       cur_id;
    logic [WIDTH-1:0] cur_data;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    int ptr_e    = 0;

    assign req_m   = sel ? '0 : req;
    assign req_e   = sel ? req : '0;
    assign ready_m = sel ? 1'b1 : ready;
    assign ready_e = sel ? ready : 1'b1;

    assign cur_gnt   = sel ? gnt_e   : gnt_m;
    assign cur_qrt   = sel ? qrt_e   : qrt_m;
    assign cur_valid = sel ? valid_e : valid_m;
    assign cur_busy  = sel ? busy_e  : busy_m;
    assign cur_id    = sel ? id_e    : id_m;
    assign cur_data  = sel ? data_e  : data_m;

    in_cell_capture_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CLR_CYC(2), .SETTLE_CYC(3)) u_dut (
        .IQC       (IQC),
        .QRT_N     (QRT_N),
        .REQ       (req_m),
        .GNT       (gnt_m),
        .CELL_QRT  (qrt_m),
        .CELL_IQZ  (iqz),
        .RSP_VALID (valid_m),
        .RSP_READY (ready_m),
        .RSP_ID    (id_m),
        .RSP_DATA  (data_m),
        .BUSY      (busy_m)
    );

    in_cell_capture_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CLR_CYC(1), .SETTLE_CYC(0)) u_edge (
        .IQC       (IQC),
        .QRT_N     (QRT_N),
        .REQ       (req_e),
        .GNT       (gnt_e),
        .CELL_QRT  (qrt_e),
        .CELL_IQZ  (iqz),
        .RSP_VALID (valid_e),
        .RSP_READY (ready_e),
        .RSP_ID    (id_e),
        .RSP_DATA  (data_e),
        .BUSY      (busy_e)
    );

    always #5 IQC = ~IQC;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the cell value present at that edge is remembered.
    task automatic step();
        @(posedge IQC);
        #1;
        iqz_at_edge = iqz;
        iqz = WIDTH'($urandom);
    endtask

    // Round-robin rule: first requester at or after the pointer, modulo NREQ.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (p + k) % NREQ;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic apply_stimulus(input logic [NREQ-1:0] reqv, input int stall, input bit keep);
        int p, idx, n, qhi, exp_lat, exp_clr;
        logic [NREQ-1:0]  eg;
        logic [WIDTH-1:0] ed;
        bit got;
        p       = sel ? ptr_e : ptr_m;
        idx     = model_pick(reqv, p);
        exp_lat = sel ? 1 + 1 + 0 + 1 : 1 + 2 + 3 + 1;
        exp_clr = sel ? 1 : 2;
        if (sel) ptr_e = (idx + 1) % NREQ;
        else     ptr_m = (idx + 1) % NREQ;
        eg    = NREQ'(1) << idx;
        req   = reqv;
        ready = (stall == 0);
        n = 0; qhi = 0; got = 0; ed = '0;
        while (!got && n < 40) begin
            step();
            n++;
            if (cur_qrt === 1'b1) qhi++;
            if (n == 1) begin
                check_output("grant", 32'(cur_gnt), 32'(eg));
                check_output("busy_granted", 32'(cur_busy), 32'd1);
                if (!keep) req = '0;
            end
            if (cur_valid === 1'b1) begin
                got = 1;
                ed  = iqz_at_edge;
            end
        end
        check_output("latency", n, exp_lat);
        check_output("qrt_cycles", qhi, exp_clr);
        check_output("rsp_id", 32'(cur_id), idx);
        check_output("rsp_data", 32'(cur_data), 32'(ed));
        check_output("gnt_held", 32'(cur_gnt), 32'(eg));
        for (int s = 0; s < stall; s++) begin
            step();
            check_output("stall_valid", 32'(cur_valid), 32'd1);
            check_output("stall_id", 32'(cur_id), idx);
            check_output("stall_data", 32'(cur_data), 32'(ed));
            check_output("stall_gnt", 32'(cur_gnt), 32'(eg));
        end
        ready = 1'b1;
        step();
        check_output("accept_valid", 32'(cur_valid), 32'd0);
        check_output("accept_gnt", 32'(cur_gnt), 32'd0);
        check_output("accept_busy", 32'(cur_busy), 32'd0);
        check_output("data_kept", 32'(cur_data), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        QRT_N = 1'b0;
        req   = '0;
        ready = 1'b0;
        sel   = 1'b0;
        iqz   = '0;

        // Reset state and release with no requests.
        repeat (3) step();
        check_output("rst_qrt", 32'(cur_qrt), 32'd1);
        check_output("rst_gnt", 32'(cur_gnt), 32'd0);
        check_output("rst_valid", 32'(cur_valid), 32'd0);
        check_output("rst_busy", 32'(cur_busy), 32'd0);
        check_output("rst_id", 32'(cur_id), 32'd0);
        check_output("rst_data", 32'(cur_data), 32'd0);
        QRT_N = 1'b1;
        #1;
        check_output("qrt_before_clk", 32'(cur_qrt), 32'd1);
        step();
        check_output("qrt_after_release", 32'(cur_qrt), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_output("idle_gnt", 32'(cur_gnt), 32'd0);
            check_output("idle_valid", 32'(cur_valid), 32'd0);
            check_output("idle_busy", 32'(cur_busy), 32'd0);
        end

        // Fairness with all requests held: 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) apply_stimulus(4'b1111, 0, 1'b1);

        // Single request, then backpressure.
        apply_stimulus(4'b0100, 0, 1'b0);
        apply_stimulus(4'b1001, 10, 1'b0);

        // Randomized traffic on the default instance.
        for (int i = 0; i < 10; i++)
            apply_stimulus(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // Edge-parameter instance: CLEAR straight to SAMPLE.
        sel = 1'b1;
        for (int i = 0; i < 6; i++)
            apply_stimulus(NREQ'($urandom_range(1, 15)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        sel = 1'b0;
        req = '0;
        step();

        // Asynchronous reset while in SETTLE.
        req   = 4'b0010;
        ready = 1'b1;
        repeat (3) step();
        check_output("pre_reset_busy", 32'(cur_busy), 32'd1);
        #2;
        QRT_N = 1'b0;
        #1;
        check_output("arst_qrt", 32'(cur_qrt), 32'd1);
        check_output("arst_gnt", 32'(cur_gnt), 32'd0);
        check_output("arst_valid", 32'(cur_valid), 32'd0);
        check_output("arst_busy", 32'(cur_busy), 32'd0);
        check_output("arst_id", 32'(cur_id), 32'd0);
        check_output("arst_data", 32'(cur_data), 32'd0);
        ptr_m = 0;
        ptr_e = 0;
        step();
        check_output("arst_no_resp", 32'(cur_valid), 32'd0);
        QRT_N = 1'b1;
        apply_stimulus(4'b0010, 0, 1'b0);
        apply_stimulus(4'b1111, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
